dest_reg_tracker: RTL and testbench
===================================

// Module: dest_reg_tracker
// PURPOSE
//  Producer side of the forwarding protocol: carries each instruction's destination
//  register and write-enable from decode through EX, MEM and WB. Drives the
//  Rd_ex/regWEN_ex and Rd_mem/regWEN_mem fields the forwarding unit consumes.
//  Detects load-use hazards that forwarding cannot cover and counts the stall cycles.
// PARAMETERS
//  REG_W  5   register index width (regbits_t)
//  CNT_W  16  load-use stall counter width
// PORTS
//  CLK          in   1      clock, rising edge
//  RST          in   1      synchronous reset, active-high
//  pipe_en      in   1      pipeline advances this cycle
//  flush_dec    in   1      kill the instruction leaving decode (taken branch/jump)
//  regWEN_dec   in   1      decode instr writes a register
//  memRead_dec  in   1      decode instr is a load
//  Rd_dec       in   REG_W  decode destination register
//  Rs_dec       in   REG_W  decode source A
//  Rt_dec       in   REG_W  decode source B
//  useRt_dec    in   1      decode instr actually reads Rt
//  regWEN_ex    out  1      EX-stage write-enable
//  Rd_ex        out  REG_W  EX-stage destination
//  regWEN_mem   out  1      MEM-stage write-enable
//  Rd_mem       out  REG_W  MEM-stage destination
//  regWEN_wb    out  1      WB-stage write-enable
//  Rd_wb        out  REG_W  WB-stage destination
//  loaduse_stall out 1      hold decode/fetch, insert bubble into EX
//  stall_count  out  CNT_W  saturating count of load-use stall cycles
// BEHAVIOUR
//  - State: three entries EX, MEM, WB, each {wen, rd, ld}; bubble = {0,0,0}.
//  - Reset (RST=1 at edge): all entries bubble, stall_count=0. loaduse_stall forced 0
//    while RST=1. Reset mid-operation discards all in-flight entries.
//  - Write to register 0 never tracked: an entry with rd=0 is stored with wen=0 and
//    ld=0, so outputs never show regWEN_*=1 with Rd_*=0.
//  - loaduse_stall (combinational, from registered EX + decode inputs):
//    EX.ld & EX.wen & (Rd_ex==Rs_dec | (useRt_dec & Rd_ex==Rt_dec)).
//  - pipe_en=0: all entries hold; flush_dec and loaduse_stall have no state effect;
//    counter holds. Upstream holds flush_dec until an advance cycle.
//  - pipe_en=1, edge update (1-cycle latency per stage):
//      WB <= MEM; MEM <= EX;
//      EX <= bubble if flush_dec | loaduse_stall,
//            else {regWEN_dec & Rd_dec!=0, Rd_dec, memRead_dec & regWEN_dec & Rd_dec!=0}.
//  - flush_dec and loaduse_stall together: single bubble into EX; counter still counts.
//  - stall_count += 1 on each edge with pipe_en & loaduse_stall; saturates at
//    2^CNT_W-1 (no wrap).
//  - After a stall bubble the load sits in MEM; same decode instr then sees no
//    load-use and forwards from MEM. Exactly one stall cycle per load-use pair.
//  - All outputs other than loaduse_stall are direct register outputs.
// TESTING
//  1 Reset: RST=1 two cycles with random inputs -> all regWEN_*=0, Rd_*=0, stall_count=0,
//    loaduse_stall=0.
//  2 Shift: pipe_en=1, dec {wen=1,Rd=8} then bubbles -> Rd_ex=8, Rd_mem=8, Rd_wb=8 on
//    cycles 1,2,3; pipe_en=0 in cycle 2 -> Rd_mem=8 holds an extra cycle.
//  3 Load-use: load Rd=9, next instr Rs=9 -> loaduse_stall=1 one cycle, regWEN_ex=0 next,
//    Rd_mem=9, stall_count=1; with Rt=9, useRt_dec=0 -> no stall.
//  4 Flush + $0: flush_dec=1 with Rd_dec=5 -> regWEN_ex=0; wen=1,Rd_dec=0 -> regWEN_ex=0,
//    and a load to $0 followed by Rs=0 -> no stall.
//  5 Saturation: CNT_W=2, four load-use stalls -> stall_count 1,2,3,3.
//  6 Reset mid-stall: loaduse_stall=1, assert RST -> next cycle all entries bubble, stall 0.

Source files
------------

// File: rtl/dest_reg_tracker.sv
// Destination-register tracker: carries {wen, rd, ld} through EX, MEM and WB for the
// forwarding unit, flags load-use hazards that need a bubble, and counts stall cycles.
module dest_reg_tracker #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             pipe_en,
  input  logic             flush_dec,
  input  logic             regWEN_dec,
  input  logic             memRead_dec,
  input  logic [REG_W-1:0] Rd_dec,
  input  logic [REG_W-1:0] Rs_dec,
  input  logic [REG_W-1:0] Rt_dec,
  input  logic             useRt_dec,
  output logic             regWEN_ex,
  output logic [REG_W-1:0] Rd_ex,
  output logic             regWEN_mem,
  output logic [REG_W-1:0] Rd_mem,
  output logic             regWEN_wb,
  output logic [REG_W-1:0] Rd_wb,
  output logic             loaduse_stall,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic             wen;
    logic [REG_W-1:0] rd;
    logic             ld;
  } entry_t;

  localparam entry_t         BUBBLE  = entry_t'({(REG_W + 2){1'b0}});
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W - 1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Register 0 is hardwired, so a write to it is never tracked as a producer.
  function automatic entry_t make_entry(input logic wen, input logic ld,
                                        input logic [REG_W-1:0] rd);
    entry_t e;
    logic   live;
    live  = wen & (rd != {REG_W{1'b0}});
    e.wen = live;
    e.rd  = rd;
    e.ld  = live & ld;
    return e;
  endfunction

  entry_t           r_ex;
  entry_t           r_mem;
  entry_t           r_wb;
  logic [CNT_W-1:0] r_cnt;

  entry_t           w_dec_entry;
  entry_t           w_ex_next;
  logic             w_src_hit;
  logic             w_stall;
  logic [CNT_W-1:0] w_cnt_next;

  // Hazard detection, next EX entry and saturating counter increment.
  always_comb begin
    w_dec_entry = make_entry(regWEN_dec, memRead_dec, Rd_dec);
    w_src_hit   = (r_ex.rd == Rs_dec) | (useRt_dec & (r_ex.rd == Rt_dec));

    if (RST) begin
      w_stall = 1'b0;
    end else begin
      w_stall = r_ex.ld & r_ex.wen & w_src_hit;
    end

    // A flush and a stall together still inject only one bubble.
    if (flush_dec | w_stall) begin
      w_ex_next = BUBBLE;
    end else begin
      w_ex_next = w_dec_entry;
    end

    if (r_cnt == CNT_MAX) begin
      w_cnt_next = r_cnt;
    end else begin
      w_cnt_next = r_cnt + CNT_ONE;
    end
  end

  // Stage shift register and stall counter; everything holds while the pipe is frozen.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ex  <= BUBBLE;
      r_mem <= BUBBLE;
      r_wb  <= BUBBLE;
      r_cnt <= {CNT_W{1'b0}};
    end else if (pipe_en) begin
      r_ex  <= w_ex_next;
      r_mem <= r_ex;
      r_wb  <= r_mem;
      if (w_stall) begin
        r_cnt <= w_cnt_next;
      end
    end
  end

  assign regWEN_ex     = r_ex.wen;
  assign Rd_ex         = r_ex.rd;
  assign regWEN_mem    = r_mem.wen;
  assign Rd_mem        = r_mem.rd;
  assign regWEN_wb     = r_wb.wen;
  assign Rd_wb         = r_wb.rd;
  assign loaduse_stall = w_stall;
  assign stall_count   = r_cnt;

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Scoreboard bench for dest_reg_tracker: each directed vector pushes its hand-computed
// expected outputs; a negedge monitor pops and compares against the DUT.
module tb_dest_reg_tracker;

  logic       CLK = 1'b0;
  logic       RST, pipe_en, flush_dec, regWEN_dec, memRead_dec, useRt_dec;
  logic [4:0] Rd_dec, Rs_dec, Rt_dec;
  logic       regWEN_ex, regWEN_mem, regWEN_wb, loaduse_stall;
  logic [4:0] Rd_ex, Rd_mem, Rd_wb;
  logic [1:0] stall_count;

  int ntests = 0;
  int nfail  = 0;
  int vidx   = 0;

  typedef struct {
    int         idx;
    logic       wx;
    logic [4:0] rx;
    logic       wm;
    logic [4:0] rm;
    logic       ww;
    logic [4:0] rw;
    logic       st;
    logic [1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  dest_reg_tracker #(.REG_W(5), .CNT_W(2)) dut (
    .CLK(CLK), .RST(RST), .pipe_en(pipe_en), .flush_dec(flush_dec),
    .regWEN_dec(regWEN_dec), .memRead_dec(memRead_dec), .Rd_dec(Rd_dec),
    .Rs_dec(Rs_dec), .Rt_dec(Rt_dec), .useRt_dec(useRt_dec),
    .regWEN_ex(regWEN_ex), .Rd_ex(Rd_ex), .regWEN_mem(regWEN_mem), .Rd_mem(Rd_mem),
    .regWEN_wb(regWEN_wb), .Rd_wb(Rd_wb), .loaduse_stall(loaduse_stall),
    .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  // Monitor: mid-cycle, compare the DUT against the oldest expectation.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      ntests++;
      if ({regWEN_ex, Rd_ex, regWEN_mem, Rd_mem, regWEN_wb, Rd_wb, loaduse_stall, stall_count}
          !== {e.wx, e.rx, e.wm, e.rm, e.ww, e.rw, e.st, e.cnt}) begin
        nfail++;
        $display("FAIL v%0d: got ex=%b/%0d mem=%b/%0d wb=%b/%0d stall=%b cnt=%0d, want ex=%b/%0d mem=%b/%0d wb=%b/%0d stall=%b cnt=%0d",
                 e.idx, regWEN_ex, Rd_ex, regWEN_mem, Rd_mem, regWEN_wb, Rd_wb,
                 loaduse_stall, stall_count, e.wx, e.rx, e.wm, e.rm, e.ww, e.rw, e.st, e.cnt);
      end
    end
  end

  // One cycle: drive decode inputs, push the outputs expected before the next edge.
  task automatic v(input logic rst, input logic en, input logic fl, input logic wen,
                   input logic ld, input int rd, input int rs, input int rt, input logic urt,
                   input logic ewx, input int erx, input logic ewm, input int erm,
                   input logic eww, input int erw, input logic est, input int ecnt);
    exp_t e;
    @(posedge CLK);
    #1;
    RST = rst; pipe_en = en; flush_dec = fl; regWEN_dec = wen; memRead_dec = ld;
    Rd_dec = rd[4:0]; Rs_dec = rs[4:0]; Rt_dec = rt[4:0]; useRt_dec = urt;
    vidx++;
    e.idx = vidx;
    e.wx = ewx; e.rx = erx[4:0]; e.wm = ewm; e.rm = erm[4:0];
    e.ww = eww; e.rw = erw[4:0]; e.st = est; e.cnt = ecnt[1:0];
    exp_q.push_back(e);
  endtask

  initial begin
    RST = 1'b1; pipe_en = 1'b1; flush_dec = 1'b0; regWEN_dec = 1'b1; memRead_dec = 1'b1;
    Rd_dec = 5'd7; Rs_dec = 5'd7; Rt_dec = 5'd7; useRt_dec = 1'b1;

    //  rst en fl wen ld rd rs rt urt | wx rx wm rm ww rw st cnt
    // reset with busy-looking inputs
    v(1, 1, 0, 1, 1,  7, 7, 7, 1,    0, 0, 0, 0, 0, 0, 0, 0);
    v(1, 0, 1, 1, 1, 19, 3, 3, 1,    0, 0, 0, 0, 0, 0, 0, 0);
    // shift with a freeze while the entry sits in MEM
    v(0, 1, 0, 1, 0,  8, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 1, 0, 0, 0,  0, 0, 0, 0,    1, 8, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0,  0, 0, 0, 0,    0, 0, 1, 8, 0, 0, 0, 0);
    v(0, 1, 0, 0, 0,  0, 0, 0, 0,    0, 0, 1, 8, 0, 0, 0, 0);
    v(0, 1, 0, 0, 0,  0, 0, 0, 0,    0, 0, 0, 0, 1, 8, 0, 0);
    // load r9 then use on Rs: one stall, then forwarded from MEM
    v(0, 1, 0, 1, 1,  9, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 1, 0, 1, 0, 10, 9, 0, 0,    1, 9, 0, 0, 0, 0, 1, 0);
    v(0, 1, 0, 1, 0, 10, 9, 0, 0,    0, 0, 1, 9, 0, 0, 0, 1);
    // Rt match ignored when useRt_dec=0
    v(0, 1, 0, 1, 1, 11, 0, 0, 0,    1,10, 0, 0, 1, 9, 0, 1);
    v(0, 1, 0, 1, 0, 12, 3,11, 0,    1,11, 1,10, 0, 0, 0, 1);
    // Rt match with useRt_dec=1 stalls
    v(0, 1, 0, 1, 1, 13, 0, 0, 0,    1,12, 1,11, 1,10, 0, 1);
    v(0, 1, 0, 1, 0, 14, 2,13, 1,    1,13, 1,12, 1,11, 1, 1);
    v(0, 1, 0, 1, 0, 14, 2,13, 1,    0, 0, 1,13, 1,12, 0, 2);
    v(0, 1, 0, 0, 0,  0, 0, 0, 0,    1,14, 0, 0, 1,13, 0, 2);
    // flush, write to r0, load to r0 followed by Rs=0
    v(0, 1, 1, 1, 0,  5, 0, 0, 0,    0, 0, 1,14, 0, 0, 0, 2);
    v(0, 1, 0, 1, 0,  0, 0, 0, 0,    0, 0, 0, 0, 1,14, 0, 2);
    v(0, 1, 0, 1, 1,  0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 2);
    v(0, 1, 0, 1, 0,  6, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 2);
    // flush and stall together: one bubble, count still advances
    v(0, 1, 0, 1, 1,  9, 0, 0, 0,    1, 6, 0, 0, 0, 0, 0, 2);
    v(0, 1, 1, 1, 0,  7, 9, 0, 0,    1, 9, 1, 6, 0, 0, 1, 2);
    v(0, 1, 0, 0, 0,  0, 0, 0, 0,    0, 0, 1, 9, 1, 6, 0, 3);
    // reset in the middle of a frozen stall
    v(0, 1, 0, 1, 1,  9, 0, 0, 0,    0, 0, 0, 0, 1, 9, 0, 3);
    v(0, 0, 0, 1, 0,  4, 9, 0, 0,    1, 9, 0, 0, 0, 0, 1, 3);
    v(1, 0, 0, 1, 0,  4, 9, 0, 0,    1, 9, 0, 0, 0, 0, 0, 3);
    v(0, 1, 0, 1, 0,  4, 9, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0);
    // four load-use pairs: counter 1,2,3,3
    v(0, 1, 0, 1, 1,  9, 0, 0, 0,    1, 4, 0, 0, 0, 0, 0, 0);
    v(0, 1, 0, 1, 0,  1, 9, 0, 0,    1, 9, 1, 4, 0, 0, 1, 0);
    v(0, 1, 0, 1, 0,  1, 9, 0, 0,    0, 0, 1, 9, 1, 4, 0, 1);
    v(0, 1, 0, 1, 1,  9, 0, 0, 0,    1, 1, 0, 0, 1, 9, 0, 1);
    v(0, 1, 0, 1, 0,  1, 9, 0, 0,    1, 9, 1, 1, 0, 0, 1, 1);
    v(0, 1, 0, 1, 0,  1, 9, 0, 0,    0, 0, 1, 9, 1, 1, 0, 2);
    v(0, 1, 0, 1, 1,  9, 0, 0, 0,    1, 1, 0, 0, 1, 9, 0, 2);
    v(0, 1, 0, 1, 0,  1, 9, 0, 0,    1, 9, 1, 1, 0, 0, 1, 2);
    v(0, 1, 0, 1, 0,  1, 9, 0, 0,    0, 0, 1, 9, 1, 1, 0, 3);
    v(0, 1, 0, 1, 1,  9, 0, 0, 0,    1, 1, 0, 0, 1, 9, 0, 3);
    v(0, 1, 0, 1, 0,  1, 9, 0, 0,    1, 9, 1, 1, 0, 0, 1, 3);
    v(0, 1, 0, 1, 0,  1, 9, 0, 0,    0, 0, 1, 9, 1, 1, 0, 3);
    v(0, 1, 0, 0, 0,  0, 0, 0, 0,    1, 1, 0, 0, 1, 9, 0, 3);

    @(negedge CLK);
    #1;
    ntests++;
    if (exp_q.size() != 0) begin
      nfail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
